// File: rtl/demultiplexer_mxn_buf.sv
// Purpose: 1-to-M stream demux; steers each input word into a per-channel 2-entry FIFO.
// Latency: 1 cycle from accepted push to out_valid/out_data on the selected channel.
// Backpressure: in_ready drops only when the selected FIFO is full; out_ready never passes through.
module demultiplexer_mxn_buf #(
    parameter  int M     = 8,
    parameter  int N     = 5,
    localparam int SEL_W = $clog2(M)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [M*N-1:0]     out_data,
    output logic [M-1:0]       out_valid,
    input  logic [M-1:0]       out_ready,
    output logic               err_sel
);

    localparam logic [SEL_W:0] M_EXT = (SEL_W+1)'(M);

    logic [1:0]   cnt_q [M];
    logic [1:0]   cnt_d [M];
    logic         wr_q  [M];
    logic         wr_d  [M];
    logic         rd_q  [M];
    logic         rd_d  [M];
    logic [N-1:0] mem_q [M][2];
    logic [N-1:0] mem_d [M][2];
    logic         err_q;
    logic         err_d;

    logic         sel_oor;
    logic         sel_full;
    logic         push_acc;

    assign sel_oor = ({1'b0, sel} >= M_EXT);

    // Ready depends only on sel and registered counts; held low while in reset.
    always_comb begin
        sel_full = 1'b0;
        for (int k = 0; k < M; k++) begin
            if ((sel == SEL_W'(k)) && (cnt_q[k] == 2'd2)) begin
                sel_full = 1'b1;
            end
        end
        in_ready = rst_n && (sel_oor || !sel_full);
    end

    assign push_acc = in_valid && in_ready && !sel_oor;
    assign err_d    = in_valid && in_ready && sel_oor;

    // Per-channel FIFO next state: at most one push (from the shared input) and one pop.
    always_comb begin
        for (int k = 0; k < M; k++) begin
            logic push_k;
            logic pop_k;
            cnt_d[k]    = cnt_q[k];
            wr_d[k]     = wr_q[k];
            rd_d[k]     = rd_q[k];
            mem_d[k][0] = mem_q[k][0];
            mem_d[k][1] = mem_q[k][1];
            push_k      = push_acc && (sel == SEL_W'(k));
            pop_k       = (cnt_q[k] != 2'd0) && out_ready[k];
            if (push_k) begin
                mem_d[k][wr_q[k]] = in_data;
                wr_d[k]           = ~wr_q[k];
            end
            if (pop_k) begin
                rd_d[k] = ~rd_q[k];
            end
            if (push_k && !pop_k) begin
                cnt_d[k] = cnt_q[k] + 2'd1;
            end else if (!push_k && pop_k) begin
                cnt_d[k] = cnt_q[k] - 2'd1;
            end
        end
    end

    // State registers; reset clears storage so heads read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < M; k++) begin
                cnt_q[k]    <= 2'd0;
                wr_q[k]     <= 1'b0;
                rd_q[k]     <= 1'b0;
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < M; k++) begin
                cnt_q[k]    <= cnt_d[k];
                wr_q[k]     <= wr_d[k];
                rd_q[k]     <= rd_d[k];
                mem_q[k][0] <= mem_d[k][0];
                mem_q[k][1] <= mem_d[k][1];
            end
            err_q <= err_d;
        end
    end

    // Head of each FIFO onto its packed slice; stale data when the channel is empty.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int k = 0; k < M; k++) begin
            out_valid[k]       = (cnt_q[k] != 2'd0);
            out_data[k*N +: N] = mem_q[k][rd_q[k]];
        end
    end

    assign err_sel = err_q;

endmodule

// File: tb/tb_demultiplexer_mxn_buf.sv
// Bench for demultiplexer_mxn_buf: an M=8/N=5 instance and an M=6/N=4 instance.
// Expected behaviour comes from per-channel queues (2-deep) updated on each accepted handshake.
module tb_demultiplexer_mxn_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] drv_sel [2];
    logic [7:0] drv_dat [2];
    logic       drv_vld [2];
    logic [7:0] drv_rdy [2];

    logic        rdy8, rdy6, err8, err6;
    logic [7:0]  vld8;
    logic [5:0]  vld6;
    logic [39:0] od8;
    logic [23:0] od6;

    demultiplexer_mxn_buf #(.M(8), .N(5)) u_m8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (drv_sel[0]),
        .in_data   (drv_dat[0][4:0]),
        .in_valid  (drv_vld[0]),
        .in_ready  (rdy8),
        .out_data  (od8),
        .out_valid (vld8),
        .out_ready (drv_rdy[0]),
        .err_sel   (err8)
    );

    demultiplexer_mxn_buf #(.M(6), .N(4)) u_m6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (drv_sel[1]),
        .in_data   (drv_dat[1][3:0]),
        .in_valid  (drv_vld[1]),
        .in_ready  (rdy6),
        .out_data  (od6),
        .out_valid (vld6),
        .out_ready (drv_rdy[1][5:0]),
        .err_sel   (err6)
    );

    logic [7:0] q [2][8][$];
    logic       err_exp [2];
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) q[d][k].delete();
            err_exp[d] = 1'b0;
        end
    endtask

    // One clock cycle: compare outputs against the queues, then advance queues by the handshakes.
    task automatic step();
        logic       push [2];
        logic [7:0] popm [2];
        #3;
        for (int d = 0; d < 2; d++) begin
            int          m;
            int          n;
            string       nm;
            logic        er;
            logic [7:0]  ev;
            logic [39:0] od;
            logic [39:0] mask;
            m    = (d == 0) ? 8 : 6;
            n    = (d == 0) ? 5 : 4;
            nm   = (d == 0) ? "m8" : "m6";
            mask = (40'd1 << n) - 40'd1;
            er   = (int'(drv_sel[d]) >= m) || (q[d][drv_sel[d]].size() < 2);
            ev   = '0;
            for (int k = 0; k < m; k++) ev[k] = (q[d][k].size() != 0);
            od   = (d == 0) ? od8 : {16'b0, od6};
            chk({nm, "_in_ready"}, (d == 0) ? rdy8 : rdy6, er);
            chk({nm, "_out_valid"}, (d == 0) ? vld8 : {2'b0, vld6}, ev);
            chk({nm, "_err_sel"}, (d == 0) ? err8 : err6, err_exp[d]);
            for (int k = 0; k < m; k++) begin
                if (ev[k]) chk($sformatf("%s_head_ch%0d", nm, k), (od >> (k*n)) & mask, q[d][k][0]);
            end
            push[d] = drv_vld[d] && er;
            popm[d] = ev & drv_rdy[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            int m;
            m = (d == 0) ? 8 : 6;
            for (int k = 0; k < m; k++) begin
                if (popm[d][k]) void'(q[d][k].pop_front());
            end
            if (push[d] && int'(drv_sel[d]) < m) q[d][drv_sel[d]].push_back(drv_dat[d]);
            err_exp[d] = push[d] && (int'(drv_sel[d]) >= m);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [2:0] s, input logic [7:0] x);
        drv_vld[d] = v;
        drv_sel[d] = s;
        drv_dat[d] = x;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b1, 3'd2, 8'h05);
        drive(1, 1'b1, 3'd1, 8'h03);
        drv_rdy[0] = 8'hFF;
        drv_rdy[1] = 8'hFF;
        clear_model();

        // Reset values while in_valid is asserted
        #12;
        chk("rst_in_ready_m8", rdy8, 0);
        chk("rst_in_ready_m6", rdy6, 0);
        chk("rst_out_valid_m8", vld8, 0);
        chk("rst_out_valid_m6", vld6, 0);
        chk("rst_out_data_m8", od8, 0);
        chk("rst_out_data_m6", od6, 0);
        chk("rst_err_m8", err8, 0);
        chk("rst_err_m6", err6, 0);
        drv_vld[0] = 1'b0;
        drv_vld[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sweep: one word per channel on consecutive cycles, all consumers ready
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b1, 3'(k), 8'(k + 1));
            step();
        end
        drv_vld[0] = 1'b0;
        step();
        chk("sweep_drained", vld8, 0);

        // Fill and stall on channel 3
        drv_rdy[0] = 8'h00;
        drive(0, 1'b1, 3'd3, 8'h0A); step();
        drive(0, 1'b1, 3'd3, 8'h0B); step();
        drive(0, 1'b1, 3'd3, 8'h0C);
        #1 chk("fill_third_rejected", rdy8, 0);
        step();
        drv_rdy[0] = 8'h08;
        #1 chk("pop_cycle_rejected", rdy8, 0);
        chk("pop_cycle_head_0A", od8[19:15], 5'h0A);
        step();
        drv_rdy[0] = 8'h00;
        #1 chk("accept_0C", rdy8, 1);
        step();
        drv_vld[0] = 1'b0;
        drv_rdy[0] = 8'h08;
        #1 chk("drain_head_0B", od8[19:15], 5'h0B);
        step();
        chk("drain_head_0C", od8[19:15], 5'h0C);
        step();
        step();
        chk("fill_drained", vld8, 0);

        // Same-cycle push and pop on channel 5
        drv_rdy[0] = 8'h00;
        drive(0, 1'b1, 3'd5, 8'h11); step();
        drive(0, 1'b1, 3'd5, 8'h12);
        drv_rdy[0] = 8'h20;
        step();
        drv_vld[0] = 1'b0;
        drv_rdy[0] = 8'h00;
        #1 chk("samecycle_valid", vld8[5], 1);
        chk("samecycle_head_12", od8[29:25], 5'h12);
        step();
        drv_rdy[0] = 8'h20;
        step();
        chk("samecycle_single_entry", vld8[5], 0);

        // Out-of-range select on the M=6 instance
        drv_rdy[1] = 8'h00;
        drive(1, 1'b1, 3'd7, 8'h0F);
        #1 chk("oor_in_ready", rdy6, 1);
        step();
        drv_vld[1] = 1'b0;
        #1 chk("oor_err_high", err6, 1);
        chk("oor_out_valid", vld6, 0);
        step();
        chk("oor_err_one_cycle", err6, 0);
        step();

        // Async reset with channels 1 and 2 full
        drv_rdy[0] = 8'hFF;
        step();
        drv_rdy[0] = 8'h00;
        drive(0, 1'b1, 3'd1, 8'h01); step();
        drive(0, 1'b1, 3'd1, 8'h02); step();
        drive(0, 1'b1, 3'd2, 8'h03); step();
        drive(0, 1'b1, 3'd2, 8'h04); step();
        chk("pre_reset_full", vld8 & 8'h06, 8'h06);
        drive(0, 1'b1, 3'd4, 8'h07);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid_m8", vld8, 0);
        chk("async_out_data_m8", od8, 0);
        chk("async_in_ready_m8", rdy8, 0);
        chk("async_out_valid_m6", vld6, 0);
        clear_model();
        @(negedge clk);
        drive(0, 1'b1, 3'd6, 8'h15);
        rst_n = 1'b1;
        step();
        drv_vld[0] = 1'b0;
        step();
        chk("post_reset_no_ch4", vld8[4], 0);

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            drive(0, ($urandom % 4) != 0, 3'($urandom % 8), 8'($urandom_range(0, 31)));
            drive(1, ($urandom % 4) != 0, 3'($urandom % 8), 8'($urandom_range(0, 15)));
            drv_rdy[0] = 8'($urandom);
            drv_rdy[1] = 8'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
